// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory unit: MMIO register offsets,
// timer CTRL bit positions and the RAM clear sweep state encoding.
package data_memory_unit_pkg;

   localparam logic [1:0] OFF_GPIO    = 2'd0;
   localparam logic [1:0] OFF_COUNT   = 2'd1;
   localparam logic [1:0] OFF_CTRL    = 2'd2;
   localparam logic [1:0] OFF_COMPARE = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_FLAG   = 2;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } dmu_state_e;

endpackage

// File: rtl/data_memory_unit_mmio_timer.sv
// Compare timer: COUNT / CTRL / COMPARE registers, match detection with
// optional reload, and a sticky write-one-to-clear match flag driving irq.
module data_memory_unit_mmio_timer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tick_en_i,
   input  logic                  wr_en_i,
   input  logic [1:0]            off_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  irq_o
);
   import data_memory_unit_pkg::*;

   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic                  en_q, en_d;
   logic                  reload_q, reload_d;
   logic                  flag_q, flag_d;
   logic                  match;
   logic                  flag_clr;

   always_comb begin
      match     = tick_en_i && en_q && (count_q == compare_q);
      flag_clr  = wr_en_i && (off_i == OFF_CTRL) && wdata_i[CTRL_FLAG];
      count_d   = count_q;
      compare_d = compare_q;
      en_d      = en_q;
      reload_d  = reload_q;
      flag_d    = flag_q;

      // A software COUNT write beats both the increment and the reload.
      if (wr_en_i && (off_i == OFF_COUNT)) begin
         count_d = wdata_i;
      end else if (tick_en_i && en_q) begin
         count_d = (match && reload_q) ? '0 : count_q + DATA_WIDTH'(1);
      end

      if (wr_en_i && (off_i == OFF_COMPARE)) begin
         compare_d = wdata_i;
      end

      if (wr_en_i && (off_i == OFF_CTRL)) begin
         en_d     = wdata_i[CTRL_EN];
         reload_d = wdata_i[CTRL_RELOAD];
      end

      // Setting on a match wins over a simultaneous W1C clear.
      if (match) begin
         flag_d = 1'b1;
      end else if (flag_clr) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q   <= '0;
         compare_q <= '0;
         en_q      <= 1'b0;
         reload_q  <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         en_q      <= en_d;
         reload_q  <= reload_d;
         flag_q    <= flag_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (off_i)
         OFF_COUNT:   rdata_o = count_q;
         OFF_CTRL:    rdata_o = {{(DATA_WIDTH-3){1'b0}}, flag_q, reload_q, en_q};
         OFF_COMPARE: rdata_o = compare_q;
         default:     rdata_o = '0;
      endcase
   end

   assign irq_o = flag_q;

endmodule

// File: rtl/data_memory_unit.sv
// Data-side memory: word RAM cleared by a post-reset sweep, GPIO register and
// compare timer in a small MMIO window, zero-latency reads for the core.
module data_memory_unit #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 256,
   parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 10'h3F0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic                  irq
);
   import data_memory_unit_pkg::*;

   localparam int                    IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] RAM_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] MMIO_SPAN = ADDR_WIDTH'(3);

   dmu_state_e            state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] gpio_q;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  ready;
   logic                  ram_hit;
   logic                  mmio_hit;
   logic [ADDR_WIDTH-1:0] mmio_off;
   logic                  ram_we;
   logic                  mmio_we;
   logic [DATA_WIDTH-1:0] timer_rdata;
   logic                  timer_irq;
   logic [DATA_WIDTH-1:0] rdata;

   // Decode is qualified by ready so the core is fully ignored during the sweep.
   always_comb begin
      ready    = (state_q == ST_READY);
      mmio_off = address - MMIO_BASE;
      ram_hit  = ready && (address <= RAM_LAST);
      mmio_hit = ready && (address >= MMIO_BASE) && (mmio_off <= MMIO_SPAN);
      ram_we   = write && ram_hit;
      mmio_we  = write && mmio_hit;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               idx_q <= idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            ST_READY: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= ST_INIT;
               idx_q   <= '0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // The array has no reset; the INIT sweep is what clears it.
   always_ff @(posedge clock) begin
      if (state_q == ST_INIT) begin
         mem[idx_q] <= '0;
      end else if (ram_we) begin
         mem[address[IDX_W-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gpio_q <= '0;
      end else if (mmio_we && (mmio_off[1:0] == OFF_GPIO)) begin
         gpio_q <= data_in;
      end
   end

   data_memory_unit_mmio_timer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_timer (
      .clk_i     (clock),
      .rst_ni    (reset),
      .tick_en_i (ready),
      .wr_en_i   (mmio_we),
      .off_i     (mmio_off[1:0]),
      .wdata_i   (data_in),
      .rdata_o   (timer_rdata),
      .irq_o     (timer_irq)
   );

   always_comb begin
      rdata = '0;
      if (read) begin
         if (ram_hit) begin
            rdata = mem[address[IDX_W-1:0]];
         end else if (mmio_hit) begin
            rdata = (mmio_off[1:0] == OFF_GPIO) ? gpio_q : timer_rdata;
         end
      end
   end

   assign data_out = rdata;
   assign busy     = busy_q;
   assign gpio_out = gpio_q;
   assign irq      = timer_irq;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed plus randomized bench for data_memory_unit against a transaction-level model.
module tb_data_memory_unit;

   localparam int          AW    = 10;
   localparam int          DW    = 32;
   localparam int          DEPTH = 256;
   localparam int          MMIO  = 'h3F0;

   logic          clock;
   logic          reset;
   logic          read;
   logic          write;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          busy;
   logic [DW-1:0] gpio_out;
   logic          irq;

   data_memory_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (DEPTH),
      .MMIO_BASE  (10'h3F0)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .read     (read),
      .write    (write),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   logic [DW-1:0] ram_m [DEPTH];
   logic [DW-1:0] gpio_m, count_m, compare_m;
   logic          en_m, reload_m, flag_m;
   int            init_cnt;

   int checks;
   int errors;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ram_m[i] = '0;
      gpio_m    = '0;
      count_m   = '0;
      compare_m = '0;
      en_m      = 1'b0;
      reload_m  = 1'b0;
      flag_m    = 1'b0;
      init_cnt  = 0;
   endtask

   function automatic logic [DW-1:0] model_read(input int a);
      if (init_cnt < DEPTH) return '0;
      if (a < DEPTH) return ram_m[a];
      case (a - MMIO)
         0: return gpio_m;
         1: return count_m;
         2: return {29'd0, flag_m, reload_m, en_m};
         3: return compare_m;
         default: return '0;
      endcase
   endfunction

   task automatic model_edge(input logic wr, input int a, input logic [DW-1:0] d);
      logic          match, clr;
      logic [DW-1:0] nxt;
      if (init_cnt < DEPTH) begin
         init_cnt++;
         return;
      end
      match = en_m && (count_m == compare_m);
      clr   = wr && (a == MMIO + 2) && d[2];
      nxt   = count_m;
      if (en_m) nxt = (match && reload_m) ? 32'd0 : count_m + 32'd1;
      if (match) flag_m = 1'b1;
      else if (clr) flag_m = 1'b0;
      if (wr) begin
         if (a < DEPTH) ram_m[a] = d;
         else if (a == MMIO + 0) gpio_m = d;
         else if (a == MMIO + 1) nxt = d;
         else if (a == MMIO + 2) begin
            en_m     = d[0];
            reload_m = d[1];
         end
         else if (a == MMIO + 3) compare_m = d;
      end
      count_m = nxt;
   endtask

   // One bus cycle: inputs applied after a posedge, outputs sampled at negedge.
   task automatic step(input logic rd, input logic wr, input int a, input logic [DW-1:0] d,
                       input bit use_want, input string tag, input logic [DW-1:0] want);
      logic [DW-1:0] exp;
      read    = rd;
      write   = wr;
      address = AW'(a);
      data_in = d;
      @(negedge clock);
      exp = rd ? model_read(a) : 32'd0;
      check("data_out", data_out, exp);
      check("busy", {31'd0, busy}, {31'd0, (init_cnt < DEPTH)});
      check("gpio_out", gpio_out, gpio_m);
      check("irq", {31'd0, irq}, {31'd0, flag_m});
      if (use_want) check(tag, data_out, want);
      @(posedge clock);
      model_edge(wr, a, d);
      #1;
   endtask

   task automatic wr_op(input int a, input logic [DW-1:0] d);
      step(1'b0, 1'b1, a, d, 1'b0, "", '0);
   endtask

   task automatic rd_op(input int a);
      step(1'b1, 1'b0, a, '0, 1'b0, "", '0);
   endtask

   task automatic rd_want(input int a, input string tag, input logic [DW-1:0] want);
      step(1'b1, 1'b0, a, '0, 1'b1, tag, want);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b0;
      read  = 1'b0;
      write = 1'b0;
      #1;
      model_reset();
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_gpio", gpio_out, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // Runs the sweep with ignored traffic and returns how many cycles busy stayed high.
   task automatic run_init(input int limit, output int n);
      n = 0;
      while (busy && n < limit) begin
         if (n % 2 == 0) step(1'b1, 1'b0, 5, '0, 1'b1, "init_read5", 32'd0);
         else step(1'b0, 1'b1, $urandom_range(0, 1023), $urandom, 1'b0, "", '0);
         n++;
      end
   endtask

   int n;

   initial begin
      checks  = 0;
      errors  = 0;
      read    = 1'b0;
      write   = 1'b0;
      address = '0;
      data_in = '0;
      reset   = 1'b0;
      @(posedge clock);
      #1;
      apply_reset(3);

      // Boot sweep length and clean RAM
      run_init(1000, n);
      check("init_cycles", n, 256);
      for (int i = 0; i < DEPTH; i++) rd_want(i, "ram_zero", 32'd0);

      // Store / load and read-during-write
      wr_op(17, 32'hDEADBEEF);
      rd_want(17, "ram17_load", 32'hDEADBEEF);
      step(1'b1, 1'b1, 17, 32'h1, 1'b1, "ram17_rw_old", 32'hDEADBEEF);
      rd_want(17, "ram17_new", 32'h1);

      // Unmapped and GPIO
      wr_op(300, 32'hFF);
      rd_want(300, "unmapped", 32'd0);
      wr_op(MMIO + 0, 32'hA5);
      check("gpio_a5", gpio_out, 32'hA5);
      rd_want(MMIO + 0, "gpio_read", 32'hA5);

      // Timer with reload
      wr_op(MMIO + 3, 32'd4);
      wr_op(MMIO + 2, 32'd3);
      for (int i = 0; i < 12; i++) rd_want(MMIO + 1, "reload_seq", 32'(i % 5));
      check("reload_irq", {31'd0, irq}, 32'd1);
      wr_op(MMIO + 2, 32'h7);
      check("w1c_clear", {31'd0, irq}, 32'd0);
      n = 0;
      while (!(flag_m && count_m == 32'd4) && n < 20) begin
         rd_op(MMIO + 1);
         n++;
      end
      check("wait_match", {31'd0, (n < 20)}, 32'd1);
      wr_op(MMIO + 2, 32'h7);
      check("set_beats_clr", {31'd0, irq}, 32'd1);
      wr_op(MMIO + 2, 32'h4);
      check("disable_clr", {31'd0, irq}, 32'd0);

      // Timer wrap
      wr_op(MMIO + 1, 32'hFFFFFFFF);
      wr_op(MMIO + 3, 32'd2);
      wr_op(MMIO + 2, 32'd1);
      rd_want(MMIO + 1, "wrap_ff", 32'hFFFFFFFF);
      rd_want(MMIO + 1, "wrap_0", 32'd0);
      rd_want(MMIO + 1, "wrap_1", 32'd1);
      check("wrap_irq_pre", {31'd0, irq}, 32'd0);
      rd_want(MMIO + 1, "wrap_2", 32'd2);
      rd_want(MMIO + 1, "wrap_3", 32'd3);
      check("wrap_irq", {31'd0, irq}, 32'd1);
      wr_op(MMIO + 2, 32'h4);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         int          cls, a;
         logic [31:0] d;
         cls = $urandom_range(0, 9);
         if (cls <= 5) a = $urandom_range(0, DEPTH - 1);
         else if (cls <= 8) a = MMIO + $urandom_range(0, 3);
         else a = ($urandom_range(0, 1) == 0) ? $urandom_range(DEPTH, MMIO - 1)
                                                : $urandom_range(MMIO + 4, 1023);
         d = $urandom;
         if (a == MMIO + 1 || a == MMIO + 3) d = $urandom_range(0, 40);
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 1'b0, "", '0);
      end

      // Poison RAM, then reset mid-sweep
      for (int i = 0; i < DEPTH; i++) wr_op(i, $urandom | 32'h1);
      wr_op(MMIO + 0, 32'h5A);
      wr_op(MMIO + 3, 32'd0);
      wr_op(MMIO + 1, 32'd0);
      wr_op(MMIO + 2, 32'd1);
      rd_op(MMIO + 2);
      apply_reset(2);
      run_init(100, n);
      check("mid_init_busy", {31'd0, busy}, 32'd1);
      apply_reset(2);
      run_init(1000, n);
      check("restart_cycles", n, 256);
      check("restart_gpio", gpio_out, 32'd0);
      check("restart_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < DEPTH; i++) rd_want(i, "poison_zero", 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
